// File: rtl/alu_req_arbiter_pkg.sv
// Shared types for the ALU request arbiter: FSM states, command constants, request record.
// alu_req_t widths are fixed here; the top-level width parameters must match them.
package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int ARB_OP_WIDTH  = 8;
  localparam int ARB_CMD_WIDTH = 4;

  localparam logic [ARB_CMD_WIDTH-1:0] CMD_MUL_A     = 4'd9;
  localparam logic [ARB_CMD_WIDTH-1:0] CMD_MUL_B     = 4'd10;
  localparam logic [ARB_CMD_WIDTH-1:0] MAX_ARITH_CMD = 4'd10;
  localparam logic [ARB_CMD_WIDTH-1:0] MAX_LOGIC_CMD = 4'd13;

  typedef struct packed {
    logic                     mode;
    logic [ARB_CMD_WIDTH-1:0] cmd;
    logic [ARB_OP_WIDTH-1:0]  opa;
    logic [ARB_OP_WIDTH-1:0]  opb;
    logic                     cin;
  } alu_req_t;

  function automatic logic is_mul_cmd(input alu_req_t r);
    return r.mode && ((r.cmd == CMD_MUL_A) || (r.cmd == CMD_MUL_B));
  endfunction

  function automatic logic is_illegal_cmd(input alu_req_t r);
    return r.mode ? (r.cmd > MAX_ARITH_CMD) : (r.cmd > MAX_LOGIC_CMD);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first request after last_grant_i, wrapping.
// Zero latency; never grants when req_i is all zero.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, issue, wait, respond (2+lat cycles min).
// Response held until rsp_ready; optional ALU_ARB_CMD_CHECK_EN short-circuits illegal commands to an error response.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int OP_WIDTH  = ARB_OP_WIDTH,
  parameter int CMD_WIDTH = ARB_CMD_WIDTH,
  parameter int ALU_LAT   = 1,
  parameter int MUL_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic                         CE,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_opa,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_opb,
  input  logic [NUM_REQ-1:0]           req_cin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [OP_WIDTH:0]            rsp_res,
  output logic [5:0]                   rsp_flags,
  output logic [1:0]                   alu_inp_valid,
  output logic                         alu_mode,
  output logic [CMD_WIDTH-1:0]         alu_cmd,
  output logic [OP_WIDTH-1:0]          alu_opa,
  output logic [OP_WIDTH-1:0]          alu_opb,
  output logic                         alu_cin,
  input  logic [OP_WIDTH:0]            alu_res,
  input  logic                         alu_err,
  input  logic                         alu_oflow,
  input  logic                         alu_cout,
  input  logic                         alu_g,
  input  logic                         alu_l,
  input  logic                         alu_e
);

  localparam int IDW     = $clog2(NUM_REQ);
  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t             state_q, state_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  alu_req_t           alu_q, alu_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [OP_WIDTH:0]  rsp_res_q, rsp_res_d;
  logic [5:0]         rsp_flags_q, rsp_flags_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gnt_idx;
  alu_req_t           sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // One-hot grant to index plus field mux of the winning requester
  always_comb begin
    gnt_idx = '0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_idx  = IDW'(i);
        sel.mode = req_mode[i];
        sel.cmd  = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
        sel.opa  = req_opa[i*OP_WIDTH +: OP_WIDTH];
        sel.opb  = req_opb[i*OP_WIDTH +: OP_WIDTH];
        sel.cin  = req_cin[i];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    cnt_d         = cnt_q;
    alu_d         = alu_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_res_d     = rsp_res_q;
    rsp_flags_d   = rsp_flags_q;
    req_ready     = '0;
    alu_inp_valid = (state_q == ISSUE) ? 2'b11 : 2'b00;

    if (CE) begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            req_ready = grant;
            id_d      = gnt_idx;
`ifdef ALU_ARB_CMD_CHECK_EN
            if (is_illegal_cmd(sel)) begin
              rsp_valid_d = 1'b1;
              rsp_res_d   = '0;
              rsp_flags_d = 6'b100000;
              state_d     = RESP;
            end else begin
              alu_d   = sel;
              state_d = ISSUE;
            end
`else
            alu_d   = sel;
            state_d = ISSUE;
`endif
          end
        end
        ISSUE: begin
          cnt_d   = is_mul_cmd(alu_q) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);
          state_d = WAIT;
        end
        WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            rsp_valid_d = 1'b1;
            rsp_res_d   = alu_res;
            rsp_flags_d = {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
            state_d     = RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
            last_grant_d = id_q;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      alu_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_res_q    <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      alu_q        <= alu_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_res_q    <= rsp_res_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_flags = rsp_flags_q;
  assign alu_mode  = alu_q.mode;
  assign alu_cmd   = alu_q.cmd;
  assign alu_opa   = alu_q.opa;
  assign alu_opb   = alu_q.opb;
  assign alu_cin   = alu_q.cin;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed steps plus random traffic against a transaction-level model.
module tb_alu_req_arbiter;

  localparam int N = 4, OPW = 8, CW = 4, ALAT = 1, MLAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST, CE, rsp_valid, rsp_ready, alu_mode, alu_cin;
  logic [N-1:0] req_valid, req_ready, req_mode, req_cin;
  logic [N*CW-1:0] req_cmd;
  logic [N*OPW-1:0] req_opa, req_opb;
  logic [1:0] rsp_id, alu_inp_valid;
  logic [OPW:0] rsp_res, alu_res;
  logic [5:0] rsp_flags;
  logic [CW-1:0] alu_cmd;
  logic [OPW-1:0] alu_opa, alu_opb;
  logic alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e;

  alu_req_arbiter #(.NUM_REQ(N), .OP_WIDTH(OPW), .CMD_WIDTH(CW), .ALU_LAT(ALAT), .MUL_LAT(MLAT)) dut (
    .clk(clk), .RST(RST), .CE(CE),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_cmd(req_cmd),
    .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
    .alu_inp_valid(alu_inp_valid), .alu_mode(alu_mode), .alu_cmd(alu_cmd), .alu_opa(alu_opa),
    .alu_opb(alu_opb), .alu_cin(alu_cin), .alu_res(alu_res), .alu_err(alu_err), .alu_oflow(alu_oflow),
    .alu_cout(alu_cout), .alu_g(alu_g), .alu_l(alu_l), .alu_e(alu_e)
  );

  // Requester state
  logic [N-1:0] pend = '0;
  logic         r_mode [N];
  logic [CW-1:0] r_cmd [N];
  logic [OPW-1:0] r_opa [N];
  logic [OPW-1:0] r_opb [N];
  logic         r_cin [N];

  always_comb begin
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_mode[i] = r_mode[i];
      req_cin[i]  = r_cin[i];
      req_cmd[i*CW +: CW]   = r_cmd[i];
      req_opa[i*OPW +: OPW] = r_opa[i];
      req_opb[i*OPW +: OPW] = r_opb[i];
    end
  end

  // Toy ALU: any deterministic function of the operands will do
  function automatic logic [8:0] ref_res(input logic m, input logic [3:0] c, input logic [7:0] a,
                                         input logic [7:0] b, input logic ci);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    if (m && (c == 4'd9 || c == 4'd10)) return p[8:0];
    if (m) return {1'b0, a} + {1'b0, b} + {8'd0, ci};
    return {1'b0, a ^ b ^ {4'd0, c}};
  endfunction

  function automatic logic [5:0] ref_flags(input logic m, input logic [3:0] c, input logic [7:0] a,
                                           input logic [7:0] b, input logic ci);
    logic [8:0] r;
    r = ref_res(m, c, a, b, ci);
    return {r[0], r[3], r[8], a > b, a < b, a == b};
  endfunction

  // ALU outputs are only valid from issue+lat onward; garbage before that
  int cyc = 0, issue_cnt = 0, alu_age = 100, b_lat = 1;
  logic l_mode = 1'b0, l_cin = 1'b0;
  logic [3:0] l_cmd = '0;
  logic [7:0] l_opa = '0, l_opb = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (RST) alu_age <= 100;
    else if (CE) begin
      if (alu_inp_valid == 2'b11) begin
        issue_cnt <= issue_cnt + 1;
        l_mode <= alu_mode; l_cmd <= alu_cmd; l_opa <= alu_opa; l_opb <= alu_opb; l_cin <= alu_cin;
        b_lat <= (alu_mode && (alu_cmd == 4'd9 || alu_cmd == 4'd10)) ? MLAT : ALAT;
        alu_age <= 0;
      end else if (alu_age < 100) alu_age <= alu_age + 1;
    end
  end

  always_comb begin
    if (alu_age >= b_lat - 1) begin
      alu_res = ref_res(l_mode, l_cmd, l_opa, l_opb, l_cin);
      {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = ref_flags(l_mode, l_cmd, l_opa, l_opb, l_cin);
    end else begin
      alu_res = 9'h155;
      {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e} = 6'b010101;
    end
  end

  int checks = 0, failures = 0, m_last = N - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input int i, input logic m, input logic [3:0] c, input logic [7:0] a,
                            input logic [7:0] b, input logic ci);
    r_mode[i] = m; r_cmd[i] = c; r_opa[i] = a; r_opb[i] = b; r_cin[i] = ci;
  endtask

  task automatic rnd_fields(input int i, input bit plain);
    set_fields(i, 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'($urandom));
    if (plain) begin
      r_mode[i] = 1'b0;
      r_cmd[i]  = 4'($urandom_range(0, 13));
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // One request through the arbiter; called and returning just after a falling edge in IDLE
  task automatic txn(input bit keep, input bit hold, input bit stall, output int g, output int gc);
    int rc, elat;
    bit ill, found, mul;
    logic [8:0] eres;
    logic [5:0] efl;
    logic [7:0] eopa;
    int iss0;
    g = rr_pick(pend, m_last);
    if (g < 0) g = 0;
    ill = 1'b0;
`ifdef ALU_ARB_CMD_CHECK_EN
    ill = (r_mode[g] && r_cmd[g] > 4'd10) || (!r_mode[g] && r_cmd[g] > 4'd13);
`endif
    mul  = r_mode[g] && (r_cmd[g] == 4'd9 || r_cmd[g] == 4'd10);
    elat = ill ? 1 : 2 + (mul ? MLAT : ALAT);
    eres = ill ? 9'd0 : ref_res(r_mode[g], r_cmd[g], r_opa[g], r_opb[g], r_cin[g]);
    efl  = ill ? 6'b100000 : ref_flags(r_mode[g], r_cmd[g], r_opa[g], r_opb[g], r_cin[g]);
    eopa = r_opa[g];
    iss0 = issue_cnt;
    found = 1'b0;
    for (int b = 0; b < 40; b++) begin
      #1;
      if (|req_ready) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("grant_seen", 32'(found), 32'd1);
    check("grant_onehot", 32'(req_ready), 32'(1 << g));
    gc = cyc;
    @(negedge clk);
    pend[g] = 1'b0;
    if (keep) begin rnd_fields(g, 1'b1); pend[g] = 1'b1; end
    if (hold) rsp_ready = 1'b0;
    #1;
    check("no_ready_after_grant", 32'(req_ready), 32'd0);
    if (!ill) begin
      check("issue_vld", 32'(alu_inp_valid), 32'd3);
      check("issue_opa", 32'(alu_opa), 32'(eopa));
    end
    if (stall) begin
      @(negedge clk);
      CE = 1'b0;
      repeat (3) @(negedge clk);
      CE = 1'b1;
      elat += 3;
    end
    found = 1'b0;
    for (int b = 0; b < 40; b++) begin
      #1;
      if (rsp_valid) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("rsp_seen", 32'(found), 32'd1);
    rc = cyc;
    check("latency", 32'(rc - gc), 32'(elat));
    check("rsp_id", 32'(rsp_id), 32'(g));
    check("rsp_res", 32'(rsp_res), 32'(eres));
    check("rsp_flags", 32'(rsp_flags), 32'(efl));
    check("issue_count", 32'(issue_cnt - iss0), ill ? 32'd0 : 32'd1);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        check("hold_vld", 32'(rsp_valid), 32'd1);
        check("hold_res", 32'(rsp_res), 32'(eres));
        check("hold_ready", 32'(req_ready), 32'd0);
        check("hold_issue", 32'(alu_inp_valid), 32'd0);
      end
      CE = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk); #1;
      check("ce_hs_ignored", 32'(rsp_valid), 32'd1);
      CE = 1'b1;
    end
    m_last = g;
    @(negedge clk);
  endtask

  int g, gc, prev;

  initial begin
    RST = 1'b1; CE = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_fields(i, 1'b0, 4'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    RST = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_inp_valid", 32'(alu_inp_valid), 32'd0);
    check("rst_rsp_res", 32'(rsp_res), 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_alu_opa", 32'(alu_opa), 32'd0);
    @(negedge clk);

    // Single add from r0
    set_fields(0, 1'b1, 4'd0, 8'h05, 8'h03, 1'b0);
    pend = 4'b0001;
    txn(1'b0, 1'b0, 1'b0, g, gc);
    check("t1_res_const", 32'(rsp_res), 32'h008);

    // Reset during WAIT aborts the multiply
    set_fields(0, 1'b1, 4'd9, 8'($urandom), 8'($urandom), 1'b0);
    pend = 4'b0001;
    #1;
    check("t6_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    pend = '0;
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    #1;
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_inp_valid", 32'(alu_inp_valid), 32'd0);
    check("t6_alu_cmd", 32'(alu_cmd), 32'd0);
    check("t6_rsp_res", 32'(rsp_res), 32'd0);
    m_last = N - 1;
    repeat (4) begin
      @(negedge clk); #1;
      check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // All four requesting continuously: 0,1,2,3,0 at one op per 3+ALU_LAT cycles
    for (int i = 0; i < N; i++) rnd_fields(i, 1'b1);
    pend = '1;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      txn(1'b1, 1'b0, 1'b0, g, gc);
      check("t2_order", 32'(rsp_id), 32'(k % N));
      if (k > 0) check("t2_period", 32'(gc - prev), 32'(3 + ALAT));
      prev = gc;
    end
    pend = '0;
    @(negedge clk);

    // Multiply latency
    set_fields(2, 1'b1, 4'd9, 8'($urandom), 8'($urandom), 1'b0);
    pend = 4'b0100;
    txn(1'b0, 1'b0, 1'b0, g, gc);

    // Response backpressure with r1 waiting
    rnd_fields(0, 1'b1); rnd_fields(1, 1'b1);
    pend = 4'b0011;
    txn(1'b0, 1'b1, 1'b0, g, gc);
    txn(1'b0, 1'b0, 1'b0, g, gc);

    // CE low in IDLE blocks acceptance, then CE low mid-WAIT delays the response
    set_fields(3, 1'b1, 4'd10, 8'($urandom), 8'($urandom), 1'b1);
    pend = 4'b1000;
    CE = 1'b0;
    #1;
    check("ce_no_ready0", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    check("ce_no_ready1", 32'(req_ready), 32'd0);
    CE = 1'b1;
    txn(1'b0, 1'b0, 1'b1, g, gc);

    // Random traffic
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin rnd_fields(i, 1'b0); pend[i] = 1'b1; end
      if (pend == '0) begin rnd_fields(t % N, 1'b0); pend[t % N] = 1'b1; end
      txn(1'b0, 1'b0, 1'b0, g, gc);
    end
    pend = '0;

`ifdef ALU_ARB_CMD_CHECK_EN
    @(negedge clk);
    set_fields(1, 1'b0, 4'd14, 8'($urandom), 8'($urandom), 1'b0);
    pend = 4'b0010;
    txn(1'b0, 1'b0, 1'b0, g, gc);
    check("ill_err_flag", 32'(rsp_flags[5]), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares one ALU instance between NUM_REQ requesters. Each request carries MODE, CMD, OPA, OPB and CIN. The block arbitrates round-robin, issues one operation at a time with INP_VALID=2'b11, waits the command-dependent latency, and captures the ALU flags and result. It then returns them on a shared response channel tagged with the requester ID. It sits between the requester fabric and the ALU input/output pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
OP_WIDTH, 8, operand width (`OP_WIDTH)
CMD_WIDTH, 4, command width (`CMD_WIDTH)
ALU_LAT, 1, cycles from issue to valid ALU outputs, ordinary commands
MUL_LAT, 2, cycles from issue to valid ALU outputs, MODE=1 and CMD 9/10

Ports:
clk  in  1  clock
RST  in  1  reset
CE  in  1  clock enable; low freezes all state and outputs
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept
req_mode  in  NUM_REQ  per-requester MODE
req_cmd  in  NUM_REQ*CMD_WIDTH  packed CMD
req_opa  in  NUM_REQ*OP_WIDTH  packed OPA
req_opb  in  NUM_REQ*OP_WIDTH  packed OPB
req_cin  in  NUM_REQ  per-requester CIN
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  requester index
rsp_res  out  OP_WIDTH+1  captured RES
rsp_flags  out  6  {ERR,OFLOW,COUT,G,L,E}
alu_inp_valid  out  2  to ALU INP_VALID
alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin  out  1/CMD_WIDTH/OP_WIDTH/OP_WIDTH/1  to ALU
alu_res  in  OP_WIDTH+1  from ALU RES
alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e  in  1 each  from ALU

Behaviour:
- Clock and reset: single clock clk. RST is synchronous, active-high.
- Reset values: state=IDLE, all outputs 0, alu_inp_valid=2'b00, last_grant=NUM_REQ-1, so requester 0 wins first.
- CE=0: no state, counter or register changes. req_ready is forced to 0 and outputs hold. A rsp_ready handshake is ignored while CE=0.
- FSM states:
  - IDLE: if any req_valid, grant g = first set bit searching from last_grant+1 with wrap. req_ready[g]=1 (combinational, IDLE only). Latch g's fields. Next state ISSUE.
  - ISSUE: one cycle. alu_inp_valid=2'b11 and the latched operands are driven. Load cnt = (mode==1 && cmd∈{9,10}) ? MUL_LAT : ALU_LAT. Next state WAIT.
  - WAIT: cnt decrements each cycle. At cnt==1, capture alu_res and flags into rsp_* and set rsp_valid=1. Next state RESP.
  - RESP: hold rsp_* stable until rsp_valid&&rsp_ready. Then rsp_valid=0, last_grant=rsp_id, next state IDLE.
- alu_inp_valid=2'b00 outside ISSUE. alu_mode/cmd/opa/opb/cin hold their last issued values.
- Minimum request-to-response latency: 2+lat cycles. With rsp_ready tied high, throughput is one op per 3+lat cycles.
- Requests arriving outside IDLE wait. req_valid must stay high until accepted.
- Simultaneous requests resolve by round-robin only. A requester that just completed has lowest priority next round.
- RST mid-operation aborts the operation. The response is never produced, and last_grant returns to NUM_REQ-1.

Optional Feature:
ALU_ARB_CMD_CHECK_EN
- Defined: in IDLE, a granted request with illegal CMD (MODE=1 && CMD>10, or MODE=0 && CMD>13) bypasses ISSUE and WAIT. Next cycle the block is in RESP with rsp_flags={1,0,0,0,0,0} and rsp_res=0, and the ALU is untouched.
- Undefined: every request is issued to the ALU, and ALU outputs are returned as-is.

Decomposition:
Shared package alu_arb_pkg holds:
- state enum {IDLE, ISSUE, WAIT, RESP}
- CMD_MUL_A=9, CMD_MUL_B=10, MAX_ARITH_CMD=10, MAX_LOGIC_CMD=13
- packed struct alu_req_t {mode, cmd, opa, opb, cin}

One sub-module, rr_arbiter: parameterised NUM_REQ, inputs req vector and last_grant, outputs a one-hot grant. It is purely combinational.

Test Plan:
1. Single request r0 (MODE=1, CMD=0, OPA=8'h05, OPB=8'h03), rsp_ready=1 -> one alu_inp_valid=11 pulse; rsp_valid after 2+ALU_LAT cycles with rsp_id=0 and rsp_res=9'h008.
2. r0..r3 all valid continuously -> grant order 0,1,2,3,0; each ID is responded to once per round.
3. MODE=1, CMD=9 multiply -> WAIT lasts MUL_LAT cycles; response at 2+MUL_LAT.
4. rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, no new issue, r1 req_ready stays 0.
5. CE=0 for 3 cycles mid-WAIT -> counter frozen; response delayed exactly 3 cycles.
6. RST asserted in WAIT -> next cycle IDLE with all outputs 0. With ALU_ARB_CMD_CHECK_EN, MODE=0 CMD=14 -> rsp_flags[5]=1 and no alu_inp_valid=11 pulse.
